inst_rom: RTL and testbench
===========================

INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, memory size in 32-bit words (power of two, >=4).
REQ-002 Parameter NOP_INST, default 32'h0000_0013, instruction returned on an error response.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 ce_i  input  1  fetch request strobe from the PC unit.
REQ-006 addr_i  input  32  fetch byte address.
REQ-007 req_ready_o  output  1  responder can accept a request this cycle.
REQ-008 inst_o  output  32  instruction word at the head of the response queue.
REQ-009 err_o  output  1  head response is misaligned or out of range.
REQ-010 inst_valid_o  output  1  head response is valid.
REQ-011 inst_ready_i  input  1  downstream consumes the head response.
REQ-012 ld_en_i  input  1  program-load write strobe.
REQ-013 ld_addr_i  input  32  program-load word index.
REQ-014 ld_data_i  input  32  program-load data.

Function
REQ-015 A request is accepted in a cycle where ce_i=1 and req_ready_o=1; ce_i=1 with req_ready_o=0 is ignored, not retried internally.
REQ-016 An accepted request enters a one-entry read stage (s1_valid, address); the memory is read synchronously in that cycle; the result is pushed into the response queue on the next edge.
REQ-017 Latency: request accepted at edge N gives inst_valid_o=1 after edge N+1 if the queue was empty.
REQ-018 The response queue is a 2-entry FIFO of {inst, err}; inst_o, err_o, inst_valid_o are driven from its head and are 0 when empty.
REQ-019 A pop occurs when inst_valid_o=1 and inst_ready_i=1; push and pop in the same cycle leave the count unchanged.
REQ-020 req_ready_o = (queue count + s1_valid) < 2, combinational from registers only; a same-cycle pop is not credited.
REQ-021 Responses are returned in request order; none is dropped or duplicated outside reset.
REQ-022 addr_i[1:0] != 0: response err=1, inst=NOP_INST; the memory array is not read.
REQ-023 Word index addr_i[31:2] >= DEPTH_WORDS: response err=1, inst=NOP_INST; the index does not wrap.
REQ-024 Otherwise: err=0, inst=mem[addr_i[31:2]].
REQ-025 ld_en_i=1 writes ld_data_i to mem[ld_addr_i] when ld_addr_i < DEPTH_WORDS; an out-of-range index is silently discarded.
REQ-026 A load and a read of the same word in the same cycle return the old data (read-before-write); the new data is visible to requests accepted from the next cycle on.
REQ-027 Loads are accepted in every cycle, independent of ce_i, req_ready_o and queue state.

Reset
REQ-028 While rst_i=1 at an edge: s1_valid=0, queue count=0, inst_o=0, err_o=0, inst_valid_o=0.
REQ-029 While rst_i=1, req_ready_o reads 1 after the first reset edge and ce_i is ignored.
REQ-030 Reset mid-operation discards all in-flight and queued responses; no response issued before reset appears after it.
REQ-031 Memory contents are not cleared by reset; loads during rst_i=1 still take effect.

Verification
REQ-032 Load mem[0]=32'h0000_0093 and mem[1]=32'h0010_0113; request addr 0x0, inst_ready_i=1 -> one cycle later inst_valid_o=1, inst_o=32'h0000_0093, err_o=0.
REQ-033 Back-to-back requests 0x0, 0x4, 0x8 with inst_ready_i=0 -> third request blocked (req_ready_o=0); queue holds mem[0], mem[1] in order; raising inst_ready_i drains them in order, then req_ready_o=1.
REQ-034 Request addr 0x2 and addr DEPTH_WORDS*4 -> two responses, each err_o=1, inst_o=32'h0000_0013.
REQ-035 Same cycle: ld_en_i=1, ld_addr_i=5, ld_data_i=32'hDEAD_BEEF, request addr 0x14 -> returns old mem[5]; repeat request -> 32'hDEAD_BEEF.
REQ-036 Queue full plus s1 occupied, assert rst_i for one cycle -> next edge inst_valid_o=0, req_ready_o=1; new request addr 0x4 returns mem[1] only.

Source files
------------

// File: rtl/inst_rom.sv
// Instruction ROM with a program-load write port, a one-entry synchronous read
// stage and a two-entry response FIFO. Fetch responses return in request order.
// Misaligned or out-of-range fetches return NOP_INST and set err.
module inst_rom #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ce_i,
  input  logic [31:0] addr_i,
  output logic        req_ready_o,
  output logic [31:0] inst_o,
  output logic        err_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  input  logic        ld_en_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } resp_t;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        s1_valid_q, s1_valid_d;
  logic        s1_err_q,   s1_err_d;
  logic [31:0] s1_rdata_q;

  resp_t       head_q, head_d;
  resp_t       tail_q, tail_d;
  logic [1:0]  count_q, count_d;

  logic        req_accept;
  logic        rd_misaligned;
  logic        rd_oor;
  logic        rd_en;
  logic        ld_in_range;
  logic        push;
  logic        pop;
  resp_t       push_resp;

  // The word index is compared at full width so large addresses never alias
  // onto a valid word.
  assign rd_misaligned = (addr_i[1:0] != 2'b00);
  assign rd_oor        = ({2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS));
  assign ld_in_range   = (ld_addr_i < 32'(DEPTH_WORDS));

  // A same-cycle pop is deliberately not credited, so ready depends only on
  // registered state.
  assign req_ready_o = (({1'b0, count_q} + {2'b00, s1_valid_q}) < 3'd2);
  assign req_accept  = ce_i & req_ready_o & ~rst_i;
  assign rd_en       = req_accept & ~rd_misaligned & ~rd_oor;

  assign push           = s1_valid_q;
  assign pop            = inst_valid_o & inst_ready_i;
  assign push_resp.inst = s1_err_q ? NOP_INST : s1_rdata_q;
  assign push_resp.err  = s1_err_q;

  assign inst_valid_o = (count_q != 2'd0);
  assign inst_o       = inst_valid_o ? head_q.inst : 32'h0;
  assign err_o        = inst_valid_o ? head_q.err  : 1'b0;

  // Program-load write port and synchronous fetch read.
  // NOTE: the memory array has no reset so it maps onto block RAM, and because
  // both the write and the read use <=, a same-edge load and fetch of one word
  // returns the old contents (read-before-write).
  always_ff @(posedge clk_i) begin
    if (ld_en_i && ld_in_range) begin
      mem_q[ld_addr_i[IDX_W-1:0]] <= ld_data_i;
    end
    if (rd_en) begin
      s1_rdata_q <= mem_q[addr_i[IDX_W+1:2]];
    end
  end

  // Next-state for the read stage and the response FIFO.
  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    s1_valid_d = req_accept;
    s1_err_d   = s1_err_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (req_accept) begin
      s1_err_d = rd_misaligned | rd_oor;
    end

    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_resp;
        else                 tail_d = push_resp;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_resp;
        end else begin
          head_d = tail_q;
          tail_d = push_resp;
        end
      end
      default: ;
    endcase
  end

  // Control state registers with synchronous reset; memory contents survive.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      count_q    <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

endmodule

// File: tb/tb_inst_rom.sv
// Scoreboard bench for inst_rom: stimulus pushes expected {inst, err} into a
// queue, an independent monitor pops and compares on each handshake.
module tb_inst_rom;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] M0    = 32'h0000_0093;
  localparam logic [31:0] M1    = 32'h0010_0113;
  localparam logic [31:0] M2    = 32'h0020_8193;
  localparam logic [31:0] M3    = 32'h3333_3333;
  localparam logic [31:0] M5    = 32'h1111_1111;
  localparam logic [31:0] M15   = 32'hCAFE_F00D;
  localparam logic [31:0] BEEF  = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ce_i;
  logic [31:0] addr_i;
  logic        req_ready_o;
  logic [31:0] inst_o;
  logic        err_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        ld_en_i;
  logic [31:0] ld_addr_i;
  logic [31:0] ld_data_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] exp_q[$];

  inst_rom #(.DEPTH_WORDS(DEPTH), .NOP_INST(NOP)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ce_i        (ce_i),
    .addr_i      (addr_i),
    .req_ready_o (req_ready_o),
    .inst_o      (inst_o),
    .err_o       (err_o),
    .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i),
    .ld_en_i     (ld_en_i),
    .ld_addr_i   (ld_addr_i),
    .ld_data_i   (ld_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [32:0] actual,
                       input logic [32:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: compare the head response against the scoreboard on each pop.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && inst_valid_o && inst_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_response: got %h, expected none", {inst_o, err_o});
        end else begin
          check("response", {inst_o, err_o}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic load(input logic [31:0] idx, input logic [31:0] data);
    ld_en_i = 1'b1; ld_addr_i = idx; ld_data_i = data;
    @(posedge clk_i); #1;
    ld_en_i = 1'b0;
  endtask

  // Issue one fetch once the DUT is ready; the expectation enters the
  // scoreboard at the same time as the request.
  task automatic req(input logic [31:0] addr, input logic [32:0] exp);
    int guard = 0;
    while (!req_ready_o && guard < 50) begin
      @(posedge clk_i); #1;
      guard++;
    end
    if (!req_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_ready_timeout: got 0, expected 1 within 50 cycles");
    end else begin
      ce_i = 1'b1; addr_i = addr;
      exp_q.push_back(exp);
      @(posedge clk_i); #1;
      ce_i = 1'b0;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk_i); #1;
      guard++;
    end
    check("drain_outstanding", 33'(exp_q.size()), 33'd0);
  endtask

  initial begin
    rst_i = 1'b1; ce_i = 1'b0; addr_i = '0; inst_ready_i = 1'b0;
    ld_en_i = 1'b0; ld_addr_i = '0; ld_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset state.
    @(negedge clk_i);
    check("rst_valid", 33'(inst_valid_o), 33'd0);
    check("rst_inst",  33'(inst_o),       33'd0);
    check("rst_err",   33'(err_o),        33'd0);
    check("rst_ready", 33'(req_ready_o),  33'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Program load; index 16 is out of range and must not wrap onto word 0.
    load(0, M0);
    load(1, M1);
    load(2, M2);
    load(5, M5);
    load(15, M15);
    load(16, 32'hBAD0_BAD0);

    // Single fetch: one cycle of latency after the accepting edge.
    inst_ready_i = 1'b1;
    req(32'h0, {M0, 1'b0});
    check("lat_not_yet", 33'(inst_valid_o), 33'd0);
    @(posedge clk_i); #1;
    check("lat_valid", 33'(inst_valid_o), 33'd1);
    check("lat_data",  {inst_o, err_o},   {M0, 1'b0});
    drain();

    // Back-to-back with a stalled consumer: third request is blocked.
    inst_ready_i = 1'b0;
    req(32'h0, {M0, 1'b0});
    req(32'h4, {M1, 1'b0});
    ce_i = 1'b1; addr_i = 32'h8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("blocked_ready", 33'(req_ready_o), 33'd0);
      @(posedge clk_i); #1;
    end
    ce_i = 1'b0;
    check("full_head", {inst_o, err_o}, {M0, 1'b0});
    inst_ready_i = 1'b1;
    drain();
    @(negedge clk_i);
    check("drained_ready", 33'(req_ready_o),  33'd1);
    check("drained_valid", 33'(inst_valid_o), 33'd0);

    // Error responses and the last valid word.
    req(32'h2,            {NOP, 1'b1});
    req(32'(DEPTH * 4),   {NOP, 1'b1});
    req(32'h3C,           {M15, 1'b0});
    req(32'h8000_0000,    {NOP, 1'b1});
    req(32'h8,            {M2, 1'b0});
    drain();

    // Load and fetch of the same word in one cycle: old data, then new.
    ld_en_i = 1'b1; ld_addr_i = 5; ld_data_i = BEEF;
    req(32'h14, {M5, 1'b0});
    ld_en_i = 1'b0;
    req(32'h14, {BEEF, 1'b0});
    drain();

    // Reset with responses in flight; a load during reset still lands.
    inst_ready_i = 1'b0;
    req(32'h0, {M0, 1'b0});
    req(32'h4, {M1, 1'b0});
    rst_i = 1'b1;
    ld_en_i = 1'b1; ld_addr_i = 3; ld_data_i = M3;
    @(posedge clk_i); #1;
    rst_i = 1'b0; ld_en_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    check("midrst_valid", 33'(inst_valid_o), 33'd0);
    check("midrst_ready", 33'(req_ready_o),  33'd1);
    inst_ready_i = 1'b1;
    req(32'h4, {M1, 1'b0});
    req(32'hC, {M3, 1'b0});
    drain();
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("final_idle", 33'(inst_valid_o), 33'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
